ppm_frame_deframer: RTL and testbench
=====================================

Name: ppm_frame_deframer

Overview:
Consumes the recovered serial bit stream (one data bit per single-cycle ready strobe) from the bit-recovery stage of the PPM optical receiver. Hunts for a 16-bit sync word, then assembles a length byte, payload bytes and a CRC-8 byte. Emits payload bytes with a valid strobe, plus a per-frame completion pulse with pass/fail status. Downstream logic (UART bridge or buffer) consumes the byte stream.

Parameters:
SYNC_WORD, 16'hD391, frame delimiter; matched MSB-first on the last 16 received bits
MAX_LEN, 64, largest legal payload length in bytes (1..255)
BIT_TIMEOUT, 16'd4000, clk cycles without a bit strobe that abort an in-progress frame

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-high reset
din  in  1  recovered data bit; valid only when drdy=1
drdy  in  1  single-cycle bit-ready strobe from the bit-recovery stage
byte_data  out  8  assembled payload byte, MSB first
byte_valid  out  1  one-cycle strobe qualifying byte_data
frame_start  out  1  one-cycle pulse when the sync word is matched
frame_len  out  8  length field of the current frame; held until the next length capture
frame_done  out  1  one-cycle pulse at frame end (good or bad)
frame_ok  out  1  qualified by frame_done: 1 = CRC good, no error
err_code  out  2  qualified by frame_done: 00 none, 01 CRC mismatch, 10 length > MAX_LEN, 11 bit timeout
in_frame  out  1  high in every state except HUNT

Behaviour:
- Reset: clock and reset as decided: one clock, clk; rst asynchronous, active-high. During rst, state = HUNT. All outputs are 0. The sync shift register, bit counter, byte shift register, CRC and timeout counter are cleared. A reset asserted mid-frame discards the frame and produces no frame_done.
- A bit event is any rising clk edge with drdy=1. All outputs are registered. Every strobe appears in the cycle after the edge that sampled the causing bit.
- States: HUNT -> LEN -> PAYLOAD -> CRC -> HUNT.
- HUNT:
  - Each bit event shifts din into a 16-bit sync register (left shift, new bit at LSB).
  - When the post-shift value equals SYNC_WORD: pulse frame_start, clear the bit counter and CRC (init 8'h00), go to LEN.
  - The sync register is cleared on every entry to HUNT, so a new frame needs 16 fresh bits.
- LEN: after 8 bits, capture frame_len and fold the byte into the CRC.
  - len > MAX_LEN: frame_done=1, frame_ok=0, err_code=10, go to HUNT.
  - len = 0: go to CRC.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Every 8 bits, pulse byte_valid with the byte and fold it into the CRC.
  - After the len-th byte, go to CRC.
  - A byte counter (8 bit) tracks progress.
- CRC:
  - After 8 bits, compare with the computed CRC and go to HUNT.
  - Pulse frame_done with frame_ok=1/err_code=00 on a match, or frame_ok=0/err_code=01 on a mismatch.
- CRC-8 definition:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Covers the length byte and the payload bytes only.
  - Bitwise update per bit event is permitted, provided the result equals the bytewise definition.
- Timeout:
  - The counter clears on every bit event and on entry to any state. It increments each cycle outside HUNT.
  - On reaching BIT_TIMEOUT: frame_done=1, frame_ok=0, err_code=11, go to HUNT.
  - If drdy arrives on the same edge the count reaches BIT_TIMEOUT, the bit wins and there is no timeout.
  - The counter saturates and does not run in HUNT.
- Payload bytes already emitted before an error are not retracted. Downstream uses frame_ok to discard the frame.
- Bits arriving after frame_done are treated as HUNT input. Back-to-back frames with no gap are supported.
- drdy held high for multiple cycles counts one bit per cycle. No edge detection is done here.
- frame_ok and err_code hold their last value between frame_done pulses.

Test Plan:
1. Good frame: bits of D391, 02, 12, 34, 27 (MSB first, drdy every 50 cycles) -> frame_start once; byte_valid twice with 0x12 then 0x34; frame_len=0x02; frame_done with frame_ok=1, err_code=00.
2. Same frame with CRC byte 0x28 -> bytes 0x12 and 0x34 emitted; frame_done with frame_ok=0, err_code=01.
3. Empty frame: D391, 00, 00 -> no byte_valid; frame_done with frame_ok=1. Then, with garbage bits 1011 prepended, a second frame is still found (sync hunt across arbitrary bit alignment).
4. Length error: D391, 0x50 (MAX_LEN=64) -> frame_done with err_code=10 one cycle after the 8th length bit; in_frame drops; a following good frame decodes correctly.
5. Timeout: D391, 03, 0xAA, then no drdy -> frame_done with err_code=11 exactly BIT_TIMEOUT cycles after the last bit. Also drdy on the BIT_TIMEOUT edge -> no timeout.
6. rst pulse during PAYLOAD -> all outputs 0 and no frame_done. A subsequent good frame (test 1 bits) passes.

Source files
------------

// File: rtl/ppm_frame_deframer.sv
// PPM receiver frame deframer.
// Hunts for a 16-bit sync word in the recovered bit stream, then assembles a
// length byte, payload bytes and a CRC-8 byte (poly 0x07, init 0x00, covering
// length + payload). Emits payload bytes and a per-frame completion status.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   din, drdy     recovered data bit, qualified by single-cycle drdy strobe
//   byte_data     assembled payload byte (MSB first), qualified by byte_valid
//   frame_start   one-cycle pulse on sync match
//   frame_len     length field of the current frame, held until next capture
//   frame_done    one-cycle pulse at frame end, qualifies frame_ok / err_code
//   frame_ok      1 = CRC good and no error
//   err_code      00 none, 01 CRC mismatch, 10 length too large, 11 bit timeout
//   in_frame      high in every state except HUNT
module ppm_frame_deframer #(
  parameter logic [15:0] SYNC_WORD   = 16'hD391,
  parameter int unsigned MAX_LEN     = 64,
  parameter logic [15:0] BIT_TIMEOUT = 16'd4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       drdy,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_start,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [1:0] err_code,
  output logic       in_frame
);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;

  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_CRC  = 2'b01;
  localparam logic [1:0]  ERR_LEN  = 2'b10;
  localparam logic [1:0]  ERR_TMO  = 2'b11;
  localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [15:0] TMO_SAT  = 16'hFFFF;

  state_t      state, state_nxt;
  logic [15:0] sync_sr, sync_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [6:0]  byte_sr, byte_sr_nxt;
  logic [7:0]  crc, crc_nxt;
  logic [7:0]  byte_cnt, byte_cnt_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;

  logic [7:0]  byte_data_nxt, frame_len_nxt;
  logic        byte_valid_nxt, frame_start_nxt, frame_done_nxt, frame_ok_nxt;
  logic [1:0]  err_code_nxt;

  logic [7:0]  shifted;
  logic [15:0] sync_shift;
  logic        byte_end;

  // Bytewise CRC-8 (poly 0x07), MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // State and datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sync_sr     <= '0;
      bit_cnt     <= '0;
      byte_sr     <= '0;
      crc         <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_len   <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_code    <= '0;
      in_frame    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sync_sr     <= sync_nxt;
      bit_cnt     <= bit_cnt_nxt;
      byte_sr     <= byte_sr_nxt;
      crc         <= crc_nxt;
      byte_cnt    <= byte_cnt_nxt;
      tmo_cnt     <= tmo_nxt;
      byte_data   <= byte_data_nxt;
      byte_valid  <= byte_valid_nxt;
      frame_start <= frame_start_nxt;
      frame_len   <= frame_len_nxt;
      frame_done  <= frame_done_nxt;
      frame_ok    <= frame_ok_nxt;
      err_code    <= err_code_nxt;
      in_frame    <= (state_nxt != HUNT);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt       = state;
    sync_nxt        = sync_sr;
    bit_cnt_nxt     = bit_cnt;
    byte_sr_nxt     = byte_sr;
    crc_nxt         = crc;
    byte_cnt_nxt    = byte_cnt;
    tmo_nxt         = tmo_cnt;
    byte_data_nxt   = byte_data;
    byte_valid_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    frame_len_nxt   = frame_len;
    frame_done_nxt  = 1'b0;
    frame_ok_nxt    = frame_ok;
    err_code_nxt    = err_code;

    shifted    = {byte_sr, din};
    sync_shift = {sync_sr[14:0], din};
    byte_end   = drdy && (bit_cnt == 3'd7);

    // Bit assembly and timeout for all in-frame states; a bit on the
    // timeout edge takes priority over the timeout.
    if (state != HUNT) begin
      if (drdy) begin
        tmo_nxt     = '0;
        byte_sr_nxt = shifted[6:0];
        bit_cnt_nxt = bit_cnt + 3'd1;
      end else if (tmo_cnt == BIT_TIMEOUT - 16'd1) begin
        frame_done_nxt = 1'b1;
        frame_ok_nxt   = 1'b0;
        err_code_nxt   = ERR_TMO;
        state_nxt      = HUNT;
      end else if (tmo_cnt != TMO_SAT) begin
        tmo_nxt = tmo_cnt + 16'd1;
      end
    end

    case (state)
      HUNT: begin
        if (drdy) begin
          sync_nxt = sync_shift;
          if (sync_shift == SYNC_WORD) begin
            frame_start_nxt = 1'b1;
            crc_nxt         = '0;
            state_nxt       = LEN;
          end
        end
      end
      LEN: begin
        if (byte_end) begin
          frame_len_nxt = shifted;
          crc_nxt       = crc8_byte(crc, shifted);
          byte_cnt_nxt  = '0;
          if (shifted > MAX_LEN8) begin
            frame_done_nxt = 1'b1;
            frame_ok_nxt   = 1'b0;
            err_code_nxt   = ERR_LEN;
            state_nxt      = HUNT;
          end else if (shifted == 8'd0) begin
            state_nxt = CRC;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_end) begin
          byte_valid_nxt = 1'b1;
          byte_data_nxt  = shifted;
          crc_nxt        = crc8_byte(crc, shifted);
          byte_cnt_nxt   = byte_cnt + 8'd1;
          if (byte_cnt + 8'd1 == frame_len) begin
            state_nxt = CRC;
          end
        end
      end
      CRC: begin
        if (byte_end) begin
          frame_done_nxt = 1'b1;
          frame_ok_nxt   = (shifted == crc);
          err_code_nxt   = (shifted == crc) ? ERR_NONE : ERR_CRC;
          state_nxt      = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase

    // Any state change restarts bit/timeout tracking; HUNT needs 16 fresh bits
    if (state_nxt != state) begin
      tmo_nxt     = '0;
      bit_cnt_nxt = '0;
      if (state_nxt == HUNT) begin
        sync_nxt = '0;
      end
    end
  end

endmodule

// File: tb/tb_ppm_frame_deframer.sv
// Testbench for ppm_frame_deframer: directed frames from the test plan plus
// randomized back-to-back frames checked against a frame-level model.
module tb_ppm_frame_deframer;

  localparam logic [15:0] SYNC = 16'hD391;
  localparam int          MAXL = 64;
  localparam int          TMO  = 4000;

  logic       clk = 1'b0;
  logic       rst, din, drdy;
  logic [7:0] byte_data, frame_len;
  logic       byte_valid, frame_start, frame_done, frame_ok, in_frame;
  logic [1:0] err_code;

  ppm_frame_deframer dut (
    .clk(clk), .rst(rst), .din(din), .drdy(drdy),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_len(frame_len), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_code(err_code), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_bit_cyc = 0;
  int gap_min = 0;
  int gap_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  logic [7:0] got_bytes[$];
  logic [2:0] got_done[$];
  int         got_done_cyc[$];
  int         start_cnt = 0;

  // Expected events
  logic [7:0] exp_bytes[$];
  logic [2:0] exp_done[$];
  int         exp_starts = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) got_bytes.push_back(byte_data);
      if (frame_start) start_cnt++;
      if (frame_done) begin
        got_done.push_back({frame_ok, err_code});
        got_done_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8: message (length + payload) divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_model(input logic [7:0] len, input logic [7:0] pl[$]);
    logic [7:0] msg[$];
    logic [8:0] rem;
    msg = pl;
    msg.push_front(len);
    rem = '0;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], 1'b0} ^ {8'h00, msg[i][b]} << 8;
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  task automatic send_bit(input logic b);
    din = b;
    drdy = 1'b1;
    @(negedge clk);
    drdy = 1'b0;
    din = 1'b0;
    last_bit_cyc = cyc;
    repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_sync();
    send_byte(SYNC[15:8]);
    send_byte(SYNC[7:0]);
  endtask

  // Full frame; a too-long length stops after the length byte
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] crcb);
    send_sync();
    send_byte(len);
    if (len <= 8'(MAXL)) begin
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(crcb);
    end
  endtask

  // Model-derived expectation for one frame
  task automatic expect_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] crcb);
    exp_starts++;
    if (len > 8'(MAXL)) begin
      exp_done.push_back(3'b0_10);
    end else begin
      foreach (pl[i]) exp_bytes.push_back(pl[i]);
      if (crcb == crc_model(len, pl)) exp_done.push_back(3'b1_00);
      else exp_done.push_back(3'b0_01);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    repeat (3) @(negedge clk);
    chk({tag, " starts"}, 32'(start_cnt), 32'(exp_starts));
    chk({tag, " byte count"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) chk({tag, " byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
    chk({tag, " done count"}, 32'(got_done.size()), 32'(exp_done.size()));
    n = (got_done.size() < exp_done.size()) ? got_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) chk({tag, " ok/err"}, 32'(got_done[i]), 32'(exp_done[i]));
    got_bytes.delete(); got_done.delete(); got_done_cyc.delete(); start_cnt = 0;
    exp_bytes.delete(); exp_done.delete(); exp_starts = 0;
  endtask

  logic [7:0]  pl[$];
  logic [7:0]  len, crcb;
  int unsigned r;
  int          t_last;

  initial begin
    rst = 1'b1; din = 1'b0; drdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({byte_data, byte_valid, frame_start, frame_len,
                              frame_done, frame_ok, err_code, in_frame}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame, drdy every 50 cycles
    gap_min = 49; gap_max = 49;
    pl = '{8'h12, 8'h34};
    send_sync();
    send_byte(8'h02);
    chk("t1 in_frame", 32'(in_frame), 32'd1);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(8'h27);
    exp_starts = 1; exp_bytes = '{8'h12, 8'h34}; exp_done = '{3'b1_00};
    check_all("t1");
    chk("t1 frame_len", 32'(frame_len), 32'h02);
    chk("t1 in_frame end", 32'(in_frame), 32'd0);

    // Bad CRC
    gap_min = 0; gap_max = 3;
    send_frame(8'h02, pl, 8'h28);
    exp_starts = 1; exp_bytes = '{8'h12, 8'h34}; exp_done = '{3'b0_01};
    check_all("t2");

    // Empty frame, then sync found after misaligned garbage
    pl.delete();
    send_frame(8'h00, pl, 8'h00);
    exp_starts = 1; exp_done = '{3'b1_00};
    check_all("t3 empty");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    pl = '{8'h5A};
    send_frame(8'h01, pl, crc_model(8'h01, pl));
    exp_starts = 1; exp_bytes = '{8'h5A}; exp_done = '{3'b1_00};
    check_all("t3 garbage");

    // Length error: done one cycle after the 8th length bit
    send_sync();
    send_byte(8'h50);
    t_last = last_bit_cyc;
    repeat (2) @(negedge clk);
    chk("t4 in_frame", 32'(in_frame), 32'd0);
    chk("t4 done cycle", 32'((got_done_cyc.size() > 0) ? got_done_cyc[0] - t_last : -1), 32'd0);
    exp_starts = 1; exp_done = '{3'b0_10};
    check_all("t4 len err");
    chk("t4 frame_len", 32'(frame_len), 32'h50);
    pl = '{8'h12, 8'h34};
    send_frame(8'h02, pl, 8'h27);
    exp_starts = 1; exp_bytes = pl; exp_done = '{3'b1_00};
    check_all("t4 recover");

    // Length boundary: MAX_LEN accepted, MAX_LEN+1 rejected
    pl.delete();
    for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
    send_frame(8'(MAXL), pl, crc_model(8'(MAXL), pl));
    expect_frame(8'(MAXL), pl, crc_model(8'(MAXL), pl));
    send_frame(8'(MAXL + 1), pl, 8'h00);
    expect_frame(8'(MAXL + 1), pl, 8'h00);
    check_all("t4 boundary");

    // Timeout exactly BIT_TIMEOUT cycles after the last bit
    gap_min = 0; gap_max = 0;
    send_sync(); send_byte(8'h03); send_byte(8'hAA);
    t_last = last_bit_cyc;
    repeat (TMO + 3) @(negedge clk);
    chk("t5 timeout cycle", 32'((got_done_cyc.size() > 0) ? got_done_cyc[0] - t_last : -1), 32'(TMO));
    exp_starts = 1; exp_bytes = '{8'hAA}; exp_done = '{3'b0_11};
    check_all("t5 timeout");

    // Bit on the timeout edge wins
    pl = '{8'hAA, 8'h0F, 8'hC3};
    send_sync(); send_byte(8'h03); send_byte(8'hAA);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h0F); send_byte(8'hC3);
    send_byte(crc_model(8'h03, pl));
    expect_frame(8'h03, pl, crc_model(8'h03, pl));
    check_all("t5 bit wins");

    // Reset during payload: outputs cleared, no frame_done
    gap_min = 0; gap_max = 2;
    send_sync(); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    send_bit(1'b1); send_bit(1'b0);
    chk("t6 in_frame", 32'(in_frame), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 reset outputs", 32'({byte_data, byte_valid, frame_start, frame_len,
                                 frame_done, frame_ok, err_code, in_frame}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    exp_starts = 1; exp_bytes = '{8'h11, 8'h22};
    check_all("t6 reset");
    pl = '{8'h12, 8'h34};
    send_frame(8'h02, pl, 8'h27);
    exp_starts = 1; exp_bytes = pl; exp_done = '{3'b1_00};
    check_all("t6 after reset");

    // Randomized back-to-back frames against the model
    gap_min = 0; gap_max = 3;
    for (int batch = 0; batch < 8; batch++) begin
      for (int k = 0; k < 3; k++) begin
        r = $urandom_range(9, 0);
        if (r == 0) len = 8'($urandom_range(255, MAXL + 1));
        else len = 8'($urandom_range(12, 0));
        pl.delete();
        for (int i = 0; i < int'(len) && len <= 8'(MAXL); i++) pl.push_back(8'($urandom));
        crcb = crc_model(len, pl);
        if ($urandom_range(3, 0) == 0) crcb = crcb ^ 8'($urandom_range(255, 1));
        send_frame(len, pl, crcb);
        expect_frame(len, pl, crcb);
      end
      check_all("rand");
      chk("rand frame_len", 32'(frame_len), 32'(len));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
